// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the register-file read stage and the RV32M
// mul/div unit. The master issues operations and the slave (the unit) returns results.
interface riscv_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit. Each operation goes through
// IDLE -> PREP -> RUN (XLEN steps) -> FIX -> DONE, and the result is held until the next FIX.
module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  riscv_muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES  = '1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        fn_reg;
  logic [XLEN-1:0]   a_reg, b_reg, opnd_reg, result_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              sign_a_reg, sign_b_reg, div0_reg, ovf_reg;
  logic              busy, done;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = PREP;
      PREP:    state_next = RUN;
      RUN:     if (cnt_reg == LAST_STEP) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = bus.start ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_reg)
      PREP, RUN, FIX: busy = 1'b1;
      DONE:           done = 1'b1;
      default:        ;
    endcase
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_reg;

  // Operand signedness as decoded from the latched funct3.
  logic            is_div, signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  assign is_div   = fn_reg[2];
  assign signed_a = (fn_reg == 3'b001) || (fn_reg == 3'b010) || (fn_reg == 3'b100) || (fn_reg == 3'b110);
  assign signed_b = (fn_reg == 3'b001) || (fn_reg == 3'b100) || (fn_reg == 3'b110);
  assign sa       = signed_a & a_reg[XLEN-1];
  assign sb       = signed_b & b_reg[XLEN-1];
  assign mag_a    = sa ? -a_reg : a_reg;
  assign mag_b    = sb ? -b_reg : b_reg;

  // acc_reg = {high, low}: product/multiplier for MUL*, remainder/quotient for DIV*.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
  assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_result;
  assign prod = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quot = (sign_a_reg ^ sign_b_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem  = sign_a_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    unique case (fn_reg)
      3'b000:                 fix_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = div0_reg ? ALL_ONES : (ovf_reg ? MIN_INT : quot);
      default:                fix_result = div0_reg ? a_reg : (ovf_reg ? '0 : rem);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fn_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      div0_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            fn_reg <= bus.funct3;
            a_reg  <= bus.op_a;
            b_reg  <= bus.op_b;
          end
        end
        PREP: begin
          sign_a_reg <= sa;
          sign_b_reg <= sb;
          opnd_reg   <= is_div ? mag_b : mag_a;
          acc_reg    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          cnt_reg    <= '0;
          div0_reg   <= is_div && (b_reg == '0);
          ovf_reg    <= is_div && !fn_reg[0] && (a_reg == MIN_INT) && (b_reg == ALL_ONES);
        end
        RUN: begin
          acc_reg <= is_div ? div_next : mul_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX:     result_reg <= fix_result;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed and randomized checks of riscv_muldiv_unit against an arithmetic
// reference model: results, latency, busy/done timing, ignored start, back-to-back issue, reset.
module tb_riscv_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  riscv_muldiv_if #(.XLEN(32)) bus ();

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic        sgn_a, sgn_b;
    sgn_a = (fn == 3'b001) || (fn == 3'b010);
    sgn_b = (fn == 3'b001);
    xa = {{32{sgn_a & a[31]}}, a};
    xb = {{32{sgn_b & b[31]}}, b};
    p  = xa * xb;
    case (fn)
      3'b000:         return p[31:0];
      3'b001, 3'b010,
      3'b011:         return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101:         return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default:        return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = fn;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
    int lat, busy_n;
    logic [31:0] prev;
    prev = bus.result;
    issue(fn, a, b);
    check({tag, "_held"}, bus.result, prev);
    wait_done(lat, busy_n);
    check({tag, "_lat"}, 32'(lat), 32'd34);
    check({tag, "_busy"}, 32'(busy_n), 32'd33);
    check({tag, "_res"}, bus.result, exp_res);
    $display("op fn=%0d a=%h b=%h -> result=%h (expected %h) latency=%0d", fn, a, b, bus.result, exp_res, lat);
  endtask

  logic [31:0] pick_vals [5];

  initial begin
    int lat, busy_n, n_done;
    logic [2:0]  fn;
    logic [31:0] a, b;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b1;

    // Directed cases
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    run_op("div0", 3'b100, 32'd1234, 32'd0, 32'hFFFF_FFFF);
    run_op("divu0", 3'b101, 32'd1234, 32'd0, 32'hFFFF_FFFF);
    run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5);
    run_op("rem0", 3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // start during RUN is ignored
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    check("ign_lat", 32'(lat), 32'd24);
    check("ign_res", bus.result, 32'd333);
    $display("ignored-start op -> result=%h latency_rem=%0d", bus.result, lat);

    // Back-to-back: start held through DONE
    issue(3'b000, 32'd11, 32'd13);
    repeat (33) @(posedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b111;
    bus.op_a   = 32'd50;
    bus.op_b   = 32'd9;
    @(posedge clk); #1;
    check("b2b_done1", 32'(bus.done), 32'd1);
    check("b2b_res1", bus.result, 32'd143);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    check("b2b_done2_low", 32'(bus.done), 32'd0);
    wait_done(lat, busy_n);
    check("b2b_lat2", 32'(lat), 32'd34);
    check("b2b_res2", bus.result, 32'd5);
    $display("back-to-back second op -> result=%h latency=%0d", bus.result, lat);

    // Reset mid-RUN abandons the operation
    issue(3'b000, 32'd3, 32'd4);
    repeat (15) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_result", bus.result, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("mrst_no_done", 32'(n_done), 32'd0);
    run_op("post_rst", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

    // Randomized operations with boundary-biased operands
    pick_vals[0] = 32'h0;
    pick_vals[1] = 32'h1;
    pick_vals[2] = 32'hFFFF_FFFF;
    pick_vals[3] = 32'h8000_0000;
    pick_vals[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? pick_vals[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pick_vals[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      run_op("rand", fn, a, b, model(fn, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
